// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage widths, refill FSM state type and line alignment helper
package fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int OFFSET_W = 4;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/icache_perf_counter.sv
// icache_perf_counter: 32-bit event counter (clk, rst, inc in; cnt out) that saturates at all-ones
module icache_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);
  always_ff @(posedge clk)
    cnt <= rst ? '0 : (inc && cnt != '1) ? cnt + 32'd1 : cnt;
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: I-cache miss/refill sequencer (fetch_* lookup in, mem_* line request/return, refill_* cache write, pc_stall out; ICACHE_PERF_EN adds hit_cnt/miss_cnt)
module icache_refill_ctrl
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              cache_hit,
  input  logic              redirect,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_line,
  output logic              refill_we,
  output logic [ADDR_W-1:0] refill_addr,
  output logic [LINE_W-1:0] refill_line,
  output logic              pc_stall
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);
  state_t r_state;
  logic   r_pend;
  logic   w_miss;
  assign w_miss = fetch_valid & ~cache_hit & ~redirect;
  assign pc_stall = r_state == IDLE ? w_miss : r_state == FILL ? ~r_pend : 1'b1;
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= IDLE;
      r_pend      <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      refill_we   <= 1'b0;
      refill_addr <= '0;
      refill_line <= '0;
    end else begin
      refill_we <= 1'b0;
      if (redirect && r_state != IDLE) r_pend <= 1'b1;
      case (r_state)
        IDLE: if (w_miss) begin
          r_state  <= REQ;
          mem_req  <= 1'b1;
          mem_addr <= line_align(fetch_addr);
        end
        REQ: r_state <= WAIT;
        WAIT: if (mem_ready) begin
          r_state     <= FILL;
          mem_req     <= 1'b0;
          refill_we   <= 1'b1;
          refill_addr <= mem_addr;
          refill_line <= mem_line;
        end
        FILL: begin
          r_state <= IDLE;
          r_pend  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
`ifdef ICACHE_PERF_EN
  logic w_cnt_en;
  assign w_cnt_en = r_state == IDLE && fetch_valid && !redirect;
  icache_perf_counter u_hit (.clk(clk), .rst(rst), .inc(w_cnt_en & cache_hit), .cnt(hit_cnt));
  icache_perf_counter u_miss (.clk(clk), .rst(rst), .inc(w_cnt_en & ~cache_hit), .cnt(miss_cnt));
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: scoreboard bench for icache_refill_ctrl (memory responder, burst/fill monitor, directed misses)
module tb_icache_refill_ctrl;
  logic         clk = 0;
  logic         rst;
  logic         fetch_valid;
  logic [31:0]  fetch_addr;
  logic         cache_hit;
  logic         redirect;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready = 0;
  logic [127:0] mem_line;
  logic         refill_we;
  logic [31:0]  refill_addr;
  logic [127:0] refill_line;
  logic         pc_stall;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif
  typedef struct {logic [31:0] a; int len;} req_t;
  typedef struct {logic [31:0] a; logic [127:0] line; bit stall; int scnt;} fill_t;
  req_t  exp_req[$];
  fill_t exp_fill[$];
  int n_pass = 0, n_tot = 0, n_fill = 0;
  int tgt = 1000, rcnt = 0;
  logic late_ready = 0;
  logic [127:0] line_drv = '0;
  assign mem_line = line_drv;
  icache_refill_ctrl dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .cache_hit(cache_hit), .redirect(redirect), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_line(mem_line), .refill_we(refill_we),
    .refill_addr(refill_addr), .refill_line(refill_line), .pc_stall(pc_stall)
`ifdef ICACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input logic [127:0] act, input logic [127:0] exp, input string nm);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  always @(negedge clk) begin
    rcnt = mem_req ? rcnt + 1 : 0;
    mem_ready = (mem_req && rcnt == tgt) || late_ready;
  end
  int blen = 0, glen = 100, scnt = 0;
  bit bstab, have_prev = 0;
  logic [31:0] baddr;
  always @(negedge clk) begin
    req_t er;
    fill_t ef;
    if (mem_req) begin
      if (blen == 0) begin
        if (have_prev) check(glen >= 2, 1, "req_gap");
        baddr = mem_addr;
        bstab = 1;
      end else bstab &= mem_addr == baddr;
      blen++;
    end else begin
      if (blen > 0) begin
        if (exp_req.size() == 0) check(blen, 0, "unexpected_req");
        else begin
          er = exp_req.pop_front();
          check(baddr, er.a, "mem_addr");
          check(blen, er.len, "req_len");
          check(bstab, 1, "mem_addr_stable");
        end
        blen = 0;
        glen = 0;
        have_prev = 1;
      end
      glen++;
    end
    if (pc_stall && (mem_req || refill_we)) scnt++;
    if (refill_we) begin
      if (exp_fill.size() == 0) check(refill_we, 0, "unexpected_fill");
      else begin
        ef = exp_fill.pop_front();
        check(refill_addr, ef.a, "refill_addr");
        check(refill_line, ef.line, "refill_line");
        check(pc_stall, ef.stall, "fill_stall");
        check(scnt, ef.scnt, "stall_cycles");
      end
      n_fill++;
      scnt = 0;
    end
    if (rst) scnt = 0;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_miss(input logic [31:0] a, input int wn, input logic [127:0] ln, input bit redir);
    int f0, k;
    f0 = n_fill;
    k = 0;
    exp_req.push_back('{a & 32'hFFFF_FFF0, wn + 1});
    exp_fill.push_back('{a & 32'hFFFF_FFF0, ln, !redir, redir ? wn + 1 : wn + 2});
    tgt = wn + 1;
    line_drv = ln;
    fetch_addr = a;
    fetch_valid = 1;
    cache_hit = 0;
    @(negedge clk);
    check(pc_stall, 1, "miss_stall");
    do begin
      tick;
      k++;
      redirect = redir && k == 2;
    end while (n_fill == f0 && k < 40);
    redirect = 0;
    check(n_fill != f0, 1, "fill_done");
    fetch_valid = 0;
  endtask
  task automatic replay;
    fetch_valid = 1;
    cache_hit = 1;
    @(negedge clk);
    check(pc_stall, 0, "replay_stall");
    tick;
    fetch_valid = 0;
    cache_hit = 0;
    @(negedge clk);
    check(mem_req, 0, "replay_no_req");
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1; fetch_valid = 0; fetch_addr = 0; cache_hit = 0; redirect = 0;
    @(posedge clk);
    @(negedge clk);
    check(mem_req, 0, "rst_mem_req");
    check(mem_addr, 0, "rst_mem_addr");
    check(refill_we, 0, "rst_refill_we");
    check(refill_addr, 0, "rst_refill_addr");
    check(refill_line, 0, "rst_refill_line");
    check(pc_stall, 0, "rst_pc_stall");
    tick;
    rst = 0;
    fetch_valid = 1; cache_hit = 1; fetch_addr = 32'h100;
    @(negedge clk);
    check(pc_stall, 0, "hit_stall");
    tick;
    @(negedge clk);
    check(mem_req, 0, "hit_no_req");
    tick;
    fetch_valid = 0;
    run_miss(32'h0000_0124, 1, 128'hDEAD_0123_4567_89AB_CDEF_FEDC_BA98_BEEF, 0);
    replay;
    run_miss(32'h0000_2008, 5, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0);
    replay;
    run_miss(32'h0000_050C, 1, 128'hA5A5_A5A5_0000_FFFF_1234_5678_9ABC_DEF0, 0);
    run_miss(32'h0000_0640, 2, 128'h0F0F_0F0F_F0F0_F0F0_0BAD_CAFE_FACE_B00C, 0);
    replay;
    run_miss(32'h0000_012C, 1, 128'hCAFE_BABE_0000_0001_0000_0002_0000_0003, 1);
    replay;
    fetch_valid = 1; cache_hit = 0; redirect = 1; fetch_addr = 32'h400;
    @(negedge clk);
    check(pc_stall, 0, "squash_stall");
    tick;
    fetch_valid = 0; redirect = 0;
    @(negedge clk);
    check(mem_req, 0, "squash_no_req");
    tick;
    tgt = 1000;
    line_drv = 128'h7777_0000_7777_0000_7777_0000_7777_0000;
    exp_req.push_back('{32'h120, 3});
    fetch_addr = 32'h128; fetch_valid = 1; cache_hit = 0;
    tick;
    tick;
    tick;
    rst = 1;
    fetch_valid = 0;
    tick;
    rst = 0;
    @(negedge clk);
    check(mem_req, 0, "midrst_mem_req");
    check(pc_stall, 0, "midrst_stall");
    tick;
    late_ready = 1;
    tick;
    late_ready = 0;
    repeat (3) tick;
    @(negedge clk);
    check(refill_we, 0, "late_ready_refill");
    check(mem_req, 0, "late_ready_req");
    check(pc_stall, 0, "late_ready_stall");
    tick;
`ifdef ICACHE_PERF_EN
    fetch_valid = 1; cache_hit = 1; fetch_addr = 32'h300;
    repeat (3) tick;
    run_miss(32'h0000_0300, 1, 128'h3030_3030_3030_3030_3030_3030_3030_3030, 0);
    @(negedge clk);
    check(hit_cnt, 3, "hit_cnt");
    check(miss_cnt, 1, "miss_cnt");
    tick;
`endif
    repeat (3) tick;
    check(exp_req.size(), 0, "req_queue_drained");
    check(exp_fill.size(), 0, "fill_queue_drained");
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
